// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor with borrow chain, LSB first, valid/ready on both sides.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             out_valid,
`ifdef SERIAL_SUB_OVERFLOW_EN
  input  logic             out_ready,
  output logic             overflow
`else
  input  logic             out_ready
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             load;
  logic             shift;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             r_bit;
  logic [WIDTH-1:0] res_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
          last      = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One full-subtractor bit slice
  always_comb begin
    d_bit   = a_sh[0] ^ b_sh[0] ^ borrow_q;
    r_bit   = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & borrow_q) | (b_sh[0] & borrow_q);
    res_nxt = {d_bit, res};
  end

  // Shift registers, bit counter and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      borrow_q   <= 1'b0;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (load) begin
        a_sh     <= minuend;
        b_sh     <= subtrahend;
        borrow_q <= borrow_in;
        cnt      <= '0;
      end
      if (shift) begin
        a_sh     <= a_sh >> 1;
        b_sh     <= b_sh >> 1;
        res      <= res_nxt[WIDTH-1:1];
        borrow_q <= r_bit;
        cnt      <= cnt + CNT_W'(1);
      end
      if (last) begin
        diff       <= res_nxt;
        borrow_out <= r_bit;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // On the last slice a_sh[0]/b_sh[0] hold the operand sign bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (last) begin
      overflow <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: model results queued at issue, checked on out_valid.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             b;
    logic             v;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             borrow_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             out_valid;
  logic             out_ready;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .borrow_in  (borrow_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .out_valid  (out_valid),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .out_ready  (out_ready),
    .overflow   (overflow)
`else
    .out_ready  (out_ready)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bi);
    logic [WIDTH:0] full;
    exp_t e;
    full = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bi);
    e.d  = full[WIDTH-1:0];
    e.b  = full[WIDTH];
    e.v  = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // All tasks start and end at a falling edge.
  task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic bi, input bit hold, output int ac);
    int n = 0;
    minuend    = a;
    subtrahend = b;
    borrow_in  = bi;
    in_valid   = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ac = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int rc);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    rc = cyc;
  endtask

  task automatic collect();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("diff", 32'(diff), 32'(e.d));
      check("borrow_out", 32'(borrow_out), 32'(e.b));
`ifdef SERIAL_SUB_OVERFLOW_EN
      check("overflow", 32'(overflow), 32'(e.v));
`endif
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    check("consume_in_ready", 32'(in_ready), 32'd1);
    check("consume_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    int ac;
    int rc;
    sb.push_back(model(a, b, bi));
    accept_op(a, b, bi, 1'b0, ac);
    wait_out(rc);
    check("latency", 32'(rc - ac), 32'(WIDTH));
    collect();
    consume();
  endtask

  initial begin
    int   ac;
    int   r1;
    int   r2;
    int   n;
    exp_t e;

    rst_n      = 1'b0;
    minuend    = '0;
    subtrahend = '0;
    borrow_in  = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow_out", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd8, 4'd3, 1'b0);
    run_op(4'd3, 4'd4, 1'b1);
    run_op(4'd0, 4'd0, 1'b1);
    run_op(4'd15, 4'd15, 1'b0);

    // Result held while the consumer stalls
    e = model(4'd5, 4'd9, 1'b0);
    sb.push_back(e);
    accept_op(4'd5, 4'd9, 1'b0, 1'b0, ac);
    wait_out(r1);
    check("stall_latency", 32'(r1 - ac), 32'(WIDTH));
    repeat (5) begin
      check("stall_diff", 32'(diff), 32'(e.d));
      check("stall_borrow", 32'(borrow_out), 32'(e.b));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    collect();
    consume();

    // Back-to-back with in_valid held and consumer always ready
    out_ready = 1'b1;
    sb.push_back(model(4'd2, 4'd1, 1'b0));
    accept_op(4'd2, 4'd1, 1'b0, 1'b1, ac);
    minuend    = 4'd1;
    subtrahend = 4'd2;
    sb.push_back(model(4'd1, 4'd2, 1'b0));
    wait_out(r1);
    check("b2b_latency", 32'(r1 - ac), 32'(WIDTH));
    collect();
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(r2);
    check("b2b_gap", 32'(r2 - r1), 32'(WIDTH + 2));
    collect();
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_done_in_ready", 32'(in_ready), 32'd1);
    check("hold_diff_after", 32'(diff), 32'd15);
    check("hold_borrow_after", 32'(borrow_out), 32'd1);

    // Reset in the second SHIFT cycle discards the operation
    accept_op(4'd9, 4'd2, 1'b0, 1'b0, ac);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow_out), 32'd0);
    repeat (WIDTH + 2) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end

    for (int a = 1; a <= 4; a++) begin
      for (int b = 1; b <= 4; b++) begin
        run_op(WIDTH'(a), WIDTH'(b), 1'(a % 2));
      end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op(4'd7, 4'd8, 1'b0);
    run_op(4'd5, 4'd2, 1'b0);
    run_op(4'd8, 4'd1, 1'b0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor with borrow-in/borrow-out. It is the inverse arithmetic counterpart to the 4-bit adder family: given a sum and one addend, it recovers the other addend.
- Processes one bit per clock, LSB first, behind a valid/ready handshake on input and output.
- Sits in the Verilog_design_styles arithmetic set as the sequential (FSM + shift register) style example.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- minuend  input  WIDTH  operand A.
- subtrahend  input  WIDTH  operand B.
- borrow_in  input  1  incoming borrow.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- diff  output  WIDTH  (A - B - borrow_in) mod 2^WIDTH.
- borrow_out  output  1  1 when A < B + borrow_in (unsigned).
- out_valid  output  1  diff/borrow_out valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset: rst_n sampled low on a rising edge forces the following; all internal shift registers and the bit counter clear.
  - state=IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0.
- Reset mid-operation (SHIFT or DONE):
  - The operation is abandoned and the result is discarded.
  - No out_valid pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture minuend, subtrahend and borrow_in into internal shift registers, clear the bit counter, then go to SHIFT.
  - Operand changes after capture have no effect.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge computes one bit from a = A[0], b = B[0] and borrow r:
    - d = a ^ b ^ r
    - r_next = (~a & b) | (~a & r) | (b & r)
  - d shifts into the MSB of the result register; A and B shift right; the counter increments.
  - After the WIDTH-th SHIFT edge, go to DONE.
- DONE:
  - out_valid=1, diff=result register, borrow_out=final r.
  - Both outputs are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE (out_valid=0, in_ready=1 on the next cycle).
- Latency:
  - out_valid rises exactly WIDTH cycles after the accept edge.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH shifts, one DONE cycle, return to IDLE.
- Back-to-back operation:
  - in_ready is 0 in DONE; a new operation cannot be accepted in the same cycle a result is consumed.
  - in_valid held high is accepted on the first IDLE edge.
- Outputs when not valid:
  - diff and borrow_out keep their last value after consumption.
  - They are only meaningful while out_valid=1.
- Arithmetic:
  - Purely unsigned; modulo 2^WIDTH wrap-around.
  - borrow_out equals the inverted carry of A + ~B + ~borrow_in.
- Boundaries:
  - 0 - 0 - 1 gives all-ones with borrow_out=1.
  - (2^WIDTH-1) - (2^WIDTH-1) - 0 gives 0 with borrow_out=0.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit), valid alongside out_valid.
  - overflow=1 when a two's-complement signed overflow occurs: the MSBs of A and B differ and the MSB of diff differs from the MSB of A. borrow_in is included in the subtraction.
  - overflow resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then A=8, B=3, borrow_in=0 -> out_valid exactly 4 cycles after the accept edge; diff=5, borrow_out=0.
- A=3, B=4, borrow_in=1 -> diff=14, borrow_out=1.
- A=0, B=0, borrow_in=1 -> diff=15, borrow_out=1.
- A=15, B=15, borrow_in=0 -> diff=0, borrow_out=0.
- out_ready held 0 for 5 cycles after out_valid -> diff and borrow_out stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
- Back-to-back with in_valid held high:
  - (2,1,0) then (1,2,0) -> results 1/0 then 15/1, second out_valid 6 cycles after the first.
- Reset asserted in the 2nd SHIFT cycle -> in_ready=1, out_valid=0, diff=0 after the reset edge.
- Loop over all A,B in 1..4, borrow_in=A%2 -> diff = (A-B-borrow_in) mod 16 every time.
- With SERIAL_SUB_OVERFLOW_EN: A=7, B=8, borrow_in=0 -> diff=15, overflow=1; A=5, B=2, borrow_in=0 -> diff=3, overflow=0.
